uart_tx_ctrl: RTL and testbench

- Transmit-side controller for the UART.
- Accepts one byte per valid/ready handshake and sequences the serial frame: start bit, data bits LSB-first, optional parity, stop bits.
- Owns the baud-interval down-counter and the bit-index counter.
- Sits between the processor's memory-mapped UART register and the tx pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_timer.sv | 26 ++
 rtl/uart_tx_ctrl.sv | 143 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types, board clocking constants and divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int UART_CLK_HZ = 100_000_000;
    localparam int UART_BAUD   = 115_200;

    // Rounded to the nearest whole clock so the baud error stays minimal.
    function automatic int calc_clk_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Baud-interval down-counter: loadable, counts to zero and holds there.
module uart_baud_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte handshake in, start/data/parity/stop frame out.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = calc_clk_per_bit(UART_CLK_HZ, UART_BAUD),
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);

    if (CLK_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_ctrl: CLK_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_db
        $error("uart_tx_ctrl: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
        $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
    end

    tx_state_e  state, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic       par_q, par_d;
    logic       serial_d, done_d;
    logic       load, zero;

    uart_baud_timer #(.W(CW)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (BIT_LAST),
        .zero     (zero)
    );

    always_comb begin
        state_d  = state;
        shift_d  = shift_q;
        bit_d    = bit_q;
        par_d    = par_q;
        serial_d = tx_serial;
        done_d   = 1'b0;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_d  = START;
                    serial_d = 1'b0;
                    shift_d  = tx_data;
                    par_d    = (^tx_data[DATA_BITS-1:0]) ^ ODD;
                    load     = 1'b1;
                end
            end
            START: begin
                if (zero) begin
                    state_d  = DATA;
                    serial_d = shift_q[0];
                    bit_d    = DATA_LAST;
                    load     = 1'b1;
                end
            end
            DATA: begin
                if (zero) begin
                    load = 1'b1;
                    if (bit_q != '0) begin
                        shift_d  = shift_q >> 1;
                        serial_d = shift_q[1];
                        bit_d    = bit_q - 3'd1;
                    end else if (PARITY_EN != 0) begin
                        state_d  = PARITY;
                        serial_d = par_q;
                    end else begin
                        state_d  = STOP;
                        serial_d = 1'b1;
                        bit_d    = STOP_LAST;
                    end
                end
            end
            PARITY: begin
                if (zero) begin
                    state_d  = STOP;
                    serial_d = 1'b1;
                    bit_d    = STOP_LAST;
                    load     = 1'b1;
                end
            end
            STOP: begin
                if (zero) begin
                    if (bit_q != '0) begin
                        bit_d = bit_q - 3'd1;
                        load  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift_q    <= '0;
            bit_q      <= '0;
            par_q      <= 1'b0;
            tx_serial  <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            par_q      <= par_d;
            tx_serial  <= serial_d;
            tx_ready   <= (state_d == IDLE);
            busy       <= (state_d != IDLE);
            frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl across five frame formats.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

    localparam int NI = 5;

    typedef struct {
        logic [7:0] d;
        int         len;
        int         par;
        int         gap;
    } exp_t;

    function automatic int cpb_of(int g);
        return (g == 4) ? 868 : 4;
    endfunction
    function automatic int db_of(int g);
        return (g == 3) ? 5 : 8;
    endfunction
    function automatic int pe_of(int g);
        return (g == 1 || g == 2) ? 1 : 0;
    endfunction
    function automatic int po_of(int g);
        return (g == 2) ? 1 : 0;
    endfunction
    function automatic int sb_of(int g);
        return (g == 3) ? 2 : 1;
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data   [NI];
    logic       valid  [NI];
    logic       ready  [NI];
    logic       serial [NI];
    logic       busy   [NI];
    logic       done   [NI];

    exp_t exp_q [NI][$];
    int   sent  [NI];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic fin    = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int CPB = cpb_of(g);
        localparam int DB  = db_of(g);
        localparam int PE  = pe_of(g);
        localparam int PO  = po_of(g);
        localparam int SB  = sb_of(g);
        localparam int LEN = (1 + DB + PE + SB) * CPB;

        int acc = 0;

        uart_tx_ctrl #(
            .CLK_PER_BIT (CPB),
            .DATA_BITS   (DB),
            .PARITY_EN   (PE),
            .PARITY_ODD  (PO),
            .STOP_BITS   (SB)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .tx_data    (data[g]),
            .tx_valid   (valid[g]),
            .tx_ready   (ready[g]),
            .tx_serial  (serial[g]),
            .busy       (busy[g]),
            .frame_done (done[g])
        );

        always @(posedge clk) begin
            if (rst && valid[g] && ready[g]) acc <= acc + 1;
        end

        // Expected line level per bit slot: start, data LSB first, parity, stops.
        function automatic logic [15:0] model(input logic [7:0] d);
            logic [15:0] fb;
            logic [7:0]  m;
            int          k;
            fb = '1;
            fb[0] = 1'b0;
            m = d & 8'((1 << DB) - 1);
            for (int j = 0; j < DB; j++) fb[1 + j] = m[j];
            k = 1 + DB;
            if (PE != 0) fb[k] = (^m) ^ (PO != 0);
            return fb;
        endfunction

        initial begin : mon
            exp_t        e;
            logic [15:0] fb;
            logic [7:0]  rx;
            logic        po;
            int          bad, bsy, t0, prev;
            bit          abort;
            prev = 0;
            forever begin
                @(negedge clk);
                if (!rst || serial[g]) continue;
                t0 = cyc;
                if (exp_q[g].size() == 0) begin
                    check($sformatf("u%0d_spurious", g), 1, 0);
                    repeat (LEN) @(negedge clk);
                    continue;
                end
                e = exp_q[g].pop_front();
                fb = model(e.d);
                bad = 0; bsy = 0; rx = '0; po = 1'b0; abort = 0;
                for (int i = 0; i < LEN; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!rst) begin
                        abort = 1;
                        break;
                    end
                    if (serial[g] !== fb[i / CPB]) bad++;
                    if (done[g] || ready[g]) bad++;
                    if (busy[g]) bsy++;
                    if (i % CPB == CPB / 2) begin
                        if (i / CPB >= 1 && i / CPB <= DB) rx[i / CPB - 1] = serial[g];
                        if (i / CPB == DB + 1) po = serial[g];
                    end
                end
                if (abort) continue;
                @(negedge clk);
                check($sformatf("u%0d_bits", g), bad, 0);
                check($sformatf("u%0d_busylen", g), bsy, e.len);
                check($sformatf("u%0d_end", g),
                      {done[g], ready[g], busy[g], serial[g]}, 4'b1101);
                check($sformatf("u%0d_data", g), rx, e.d & 8'((1 << DB) - 1));
                if (e.par >= 0) check($sformatf("u%0d_par", g), po, e.par);
                if (e.gap > 0) check($sformatf("u%0d_gap", g), t0 - prev, e.gap);
                prev = t0;
            end
        end

        initial begin : tally
            wait (fin);
            check($sformatf("u%0d_accepts", g), acc, sent[g]);
            check($sformatf("u%0d_qleft", g), exp_q[g].size(), 0);
        end
    end

    task automatic wait_ready(input int g);
        int n = 0;
        @(negedge clk);
        while (!ready[g] && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!ready[g]) check($sformatf("u%0d_ready_to", g), 0, 1);
    endtask

    task automatic send(input int g, input logic [7:0] d,
                        input int len, input int par);
        wait_ready(g);
        exp_q[g].push_back('{d, len, par, 0});
        sent[g]++;
        data[g]  = d;
        valid[g] = 1'b1;
        @(posedge clk);
        #1 valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int n = 0;
        @(negedge clk);
        while ((busy[g] || exp_q[g].size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (busy[g]) check($sformatf("u%0d_idle_to", g), 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : wdog
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin : stim
        int dly;
        for (int g = 0; g < NI; g++) begin
            data[g]  = '0;
            valid[g] = 1'b0;
            sent[g]  = 0;
        end
        #12;
        check("rst_state",
              {ready[0], serial[0], busy[0], done[0]}, 4'b1100);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy[0], 0);

        // 8N1 single frame
        send(0, 8'hA5, 40, -1);
        wait_idle(0);

        // asynchronous resets at several points in a frame
        for (int r = 0; r < 3; r++) begin
            dly = (r == 0) ? 15 : $urandom_range(2, 38);
            send(0, 8'hC3, 40, -1);
            repeat (dly) @(posedge clk);
            #2 rst = 1'b0;
            #1;
            check("rst_async_serial", serial[0], 1);
            check("rst_async_ready", ready[0], 1);
            check("rst_async_busy", busy[0], 0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("rst_release_busy", busy[0], 0);
        end
        send(0, 8'hA5, 40, -1);
        wait_idle(0);

        // parity even / odd
        send(1, 8'h07, 44, 1);
        send(2, 8'h07, 44, 0);
        wait_idle(1);
        wait_idle(2);
        send(1, 8'h80, 44, 1);
        send(2, 8'h3C, 44, 1);
        wait_idle(1);
        wait_idle(2);

        // back-to-back with valid held high
        wait_ready(0);
        exp_q[0].push_back('{8'h55, 40, -1, 0});
        sent[0]++;
        data[0]  = 8'h55;
        valid[0] = 1'b1;
        @(posedge clk);
        #1;
        exp_q[0].push_back('{8'h0F, 40, -1, 41});
        sent[0]++;
        data[0] = 8'h0F;
        wait_ready(0);
        @(posedge clk);
        #1 valid[0] = 1'b0;
        wait_idle(0);

        // tx_data churns while busy
        send(0, 8'h3C, 40, -1);
        for (int i = 0; i < 38; i++) begin
            @(negedge clk);
            data[0] = 8'($urandom);
        end
        wait_idle(0);

        // 5 data bits, 2 stop bits
        send(3, 8'hFF, 32, -1);
        wait_idle(3);
        send(3, 8'hB2, 32, -1);
        wait_idle(3);

        // large divider
        send(4, 8'h00, 8680, -1);
        wait_idle(4);

        fin = 1'b1;
        #100;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
